// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared opcodes, FSM encoding and widths for the register-file sequencer
package rf_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;
endpackage

// File: rtl/rf_sequencer_if.sv
// rtl/rf_sequencer_if.sv - instruction handshake, register-file ports and status of the sequencer
interface rf_sequencer_if;
  import rf_pkg::*;

  logic [7:0]        INSTR;
  logic              INSTR_VALID;
  logic              INSTR_READY;
  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic [DATA_W-1:0] CRS;
  logic [DATA_W-1:0] CRT;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] DW;
  logic              RG_WE;
  logic [DATA_W-1:0] RESULT;
  logic              DONE;
  logic              FLAG_Z;
  logic              FLAG_C;

  // master is the sequencer; slave is the instruction source plus register file
  modport master (
    input  INSTR, INSTR_VALID, CRS, CRT,
    output INSTR_READY, RS, RT, RW, DW, RG_WE, RESULT, DONE, FLAG_Z, FLAG_C
  );
  modport slave (
    output INSTR, INSTR_VALID, CRS, CRT,
    input  INSTR_READY, RS, RT, RW, DW, RG_WE, RESULT, DONE, FLAG_Z, FLAG_C
  );
endinterface

// File: rtl/rf_seq_alu.sv
// rtl/rf_seq_alu.sv - combinational ALU; bit DATA_W of the wide result is carry or borrow
module rf_seq_alu
  import rf_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c
);
  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_LDI:  wide = {1'b0, b};
      default: wide = {1'b0, a};
    endcase
  end

  assign y = wide[DATA_W-1:0];
  assign c = wide[DATA_W];
endmodule

// File: rtl/rf_sequencer.sv
// rtl/rf_sequencer.sv - four-state micro-sequencer: read two registers, compute, write back
module rf_sequencer
  import rf_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  rf_sequencer_if.master bus
);
  state_t            state, nxt;
  logic [7:0]        instr_q;
  logic [DATA_W-1:0] opa, opb, result_q;
  logic              fz, fc;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_c;

  assign op_q = instr_q[7:6];
  assign rd_q = instr_q[5:4];
  assign rs_q = instr_q[3:2];
  assign rt_q = instr_q[1:0];

  // LDI takes its immediate from the rs/rt fields rather than the read ports
  assign alu_b = (op_q == OP_LDI) ? {rs_q, rt_q} : opb;

  rf_seq_alu u_alu (
    .op (op_q),
    .a  (opa),
    .b  (alu_b),
    .y  (alu_y),
    .c  (alu_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (bus.INSTR_VALID) nxt = S_READ;
      S_READ:  nxt = S_EXEC;
      S_EXEC:  nxt = S_WB;
      S_WB:    nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.INSTR_READY = (state == S_IDLE);
    bus.RS          = '0;
    bus.RT          = '0;
    bus.RW          = '0;
    bus.DW          = '0;
    bus.RG_WE       = 1'b0;
    bus.DONE        = 1'b0;
    case (state)
      S_READ: begin
        bus.RS = rs_q;
        bus.RT = rt_q;
      end
      S_WB: begin
        bus.RW    = rd_q;
        bus.DW    = result_q;
        bus.RG_WE = (op_q != OP_OUT);
        bus.DONE  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.RESULT = result_q;
  assign bus.FLAG_Z = fz;
  assign bus.FLAG_C = fc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_q  <= '0;
      opa      <= '0;
      opb      <= '0;
      result_q <= '0;
      fz       <= 1'b0;
      fc       <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.INSTR_VALID) instr_q <= bus.INSTR;
      if (state == S_READ) begin
        opa <= bus.CRS;
        opb <= bus.CRT;
      end
      if (state == S_EXEC) begin
        result_q <= alu_y;
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          fz <= (alu_y == '0);
          fc <= alu_c;
        end
      end
    end
  end
endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Multi-cycle micro-sequencer that drives the 4-entry × 4-bit register file from the initiator side. It accepts one 8-bit instruction per valid/ready handshake and reads two source registers through the file's combinational read ports. It then computes a 4-bit result and writes it back through the file's single write port. It sits between the instruction source and the register file, and is the only agent allowed to drive the file's write port.

## Interface
Parameters:
- DATA_W, 4, register data width; fixed by the register file.
- ADDR_W, 2, register index width (4 registers).

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- INSTR  in  8  instruction: [7:6] op, [5:4] rd, [3:2] rs, [1:0] rt.
- INSTR_VALID  in  1  INSTR is valid.
- INSTR_READY  out  1  sequencer can accept an instruction.
- RS  out  2  read-port-A index to the register file.
- RT  out  2  read-port-B index to the register file.
- CRS  in  4  read-port-A data, combinational from RS.
- CRT  in  4  read-port-B data, combinational from RT.
- RW  out  2  write index.
- DW  out  4  write data.
- RG_WE  out  1  write enable; the file commits DW to RW at the rising edge while high.
- RESULT  out  4  last computed value; valid while DONE is high.
- DONE  out  1  one-cycle pulse per completed instruction.
- FLAG_Z  out  1  last ADD/SUB result was zero.
- FLAG_C  out  1  ADD carry-out or SUB borrow.

## Operation
Opcodes:
- 00 ADD: rd = rs + rt mod 16; C = carry out of bit 3.
- 01 SUB: rd = rs − rt mod 16; C = 1 when rs < rt (borrow).
- 10 LDI: rd = {rs, rt} as a 4-bit immediate; no register read is used; flags unchanged.
- 11 OUT: RESULT = value of rs; no write (RG_WE stays 0); flags unchanged.

FSM states are IDLE → READ → EXEC → WB → IDLE.
- IDLE: INSTR_READY=1. On INSTR_VALID & INSTR_READY, latch INSTR and go to READ. Otherwise stay in IDLE.
- READ: RS and RT are driven from the latched rs and rt. CRS and CRT are captured into operand registers at the closing edge.
- EXEC: the ALU computes from the operand registers. RESULT, FLAG_Z and FLAG_C are registered at the closing edge. Flag update happens for ADD/SUB only.
- WB: RW = rd and DW = RESULT. RG_WE=1 for ADD, SUB and LDI; RG_WE=0 for OUT. DONE=1 for exactly this cycle.

Signal rules:
- Outside READ, RS=0 and RT=0.
- Outside WB, RW=0, DW=0, RG_WE=0 and DONE=0.
- RESULT and the flags hold their values until the next EXEC.
- Instructions are fully serialized, so no read-after-write hazard exists. The next instruction's READ always follows the previous WB edge.
- INSTR is ignored whenever INSTR_READY=0.

## Timing
- Handshake edge is t0. READ runs in cycle t0+1, EXEC in t0+2, and WB/DONE in t0+3.
- The register write commits at the end of t0+3.
- INSTR_READY returns high in t0+4.
- Maximum throughput is one instruction per 4 cycles.
- INSTR_READY is decoded from the state (IDLE), not from INSTR_VALID.

Reset (RST=1, asynchronous):
- State goes to IDLE immediately.
- INSTR_READY=1.
- RS, RT, RW, DW, RG_WE, RESULT, DONE, FLAG_Z and FLAG_C all read 0.
- RST asserted in any state aborts the instruction: no write occurs and DONE is not pulsed.
- RST asserted during WB drops RG_WE before the edge.

Arithmetic is 5-bit internally. The low 4 bits form the result; bit 4 forms the carry or borrow.

## Structure
- Shared package rf_pkg holds:
  - op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_LDI=2'b10, OP_OUT=2'b11;
  - FSM state encoding S_IDLE/S_READ/S_EXEC/S_WB;
  - DATA_W and ADDR_W.
- One sub-module, rf_seq_alu: combinational; inputs op and a/b (4 bits); outputs y (4 bits) and c.
- The FSM, the instruction latch and the operand registers stay in rf_sequencer.

## Test plan
- Reset then LDI: RST pulse, then INSTR=8'b10_01_10_11 (r1=0xB) → DONE at t0+3 with RW=1, DW=0xB, RG_WE=1; the file's r1 reads 0xB afterwards.
- ADD with carry: r1=0xB, r2=0x7, INSTR=ADD r3,r1,r2 → RESULT=0x2, FLAG_C=1, FLAG_Z=0; r3=0x2.
- SUB to zero: r1=r2=0x5, SUB r0,r1,r2 → RESULT=0x0, FLAG_Z=1, FLAG_C=0. SUB r0,r2,r1 with r2=0x3, r1=0x5 → RESULT=0xE, FLAG_C=1.
- OUT: r3=0x9, OUT rs=3 → RESULT=0x9, DONE=1, RG_WE=0 throughout; flags unchanged from the previous instruction.
- Back-to-back and stalls:
  - INSTR_VALID held high with 3 queued instructions → accepts exactly every 4th cycle;
  - INSTR_READY=0 in READ/EXEC/WB;
  - the second instruction reads the first's rd value.
- Reset mid-operation: assert RST in EXEC of ADD r2,… → RG_WE never rises, r2 unchanged, DONE stays 0, INSTR_READY=1 and the flags read 0 immediately after RST.
